// File: rtl/meas_seq_pkg.sv
// Shared types and widths for the measurement run controller.
package meas_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ABORT = 3'd6
  } state_e;

  localparam int RUNS_W  = 16;
  localparam int TIME_W  = 32;
  localparam int WORDS_W = 16;
  localparam int GAP_W   = 32;
  localparam int PKT_W   = 32;

  // A zero run count still means one measurement.
  function automatic logic [RUNS_W-1:0] runs_eff(input logic [RUNS_W-1:0] r);
    runs_eff = (r == 16'd0) ? 16'd1 : r;
  endfunction

  function automatic logic [PKT_W-1:0] sat_inc(input logic [PKT_W-1:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with zero flag; parks at zero until reloaded.
module seq_timer #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/measurement_sequencer.sv
// Run controller for signal_detector_v1_0: latches a run configuration, sequences
// back-to-back measurements and counts AXIS packets by snooping tlast beats.
module measurement_sequencer
  import meas_seq_pkg::*;
#(
  parameter int WATCHDOG_W = 32,
  parameter int ARM_CYCLES = 4
) (
  input  logic               m00_axis_aclk,
  input  logic               m00_axis_areset,
  input  logic               start,
  input  logic               abort,
  input  logic [RUNS_W-1:0]  cfg_runs,
  input  logic [TIME_W-1:0]  cfg_measurement_time,
  input  logic [WORDS_W-1:0] cfg_number_words,
  input  logic [GAP_W-1:0]   cfg_gap_cycles,
  input  logic               det_stopped,
  input  logic               mon_tvalid,
  input  logic               mon_tready,
  input  logic               mon_tlast,
  output logic               det_enabled,
  output logic               det_trigger,
  output logic [TIME_W-1:0]  det_measurement_time,
  output logic [WORDS_W-1:0] det_number_words,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [RUNS_W-1:0]  run_count,
  output logic [PKT_W-1:0]   packet_count
);

  localparam int TW = (WATCHDOG_W > GAP_W) ? WATCHDOG_W : GAP_W;
  localparam logic [WATCHDOG_W-1:0] WD_MAX = '1;
  // Zero is detected one cycle after it is reached, so every load is one short.
  localparam logic [TW-1:0] WD_LOAD  = TW'(WD_MAX) - TW'(1);
  localparam logic [TW-1:0] ARM_LOAD = TW'(ARM_CYCLES - 1);

  state_e state_q, state_d;
  logic en_q, en_d, trig_q, trig_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [RUNS_W-1:0]  runs_q, runs_d, run_count_q, run_count_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [WORDS_W-1:0] words_q, words_d;
  logic [PKT_W-1:0]   pkt_q, pkt_d;

  logic          beat_s, start_ok_s, abort_hit_s, drain_exit_s, last_run_s;
  logic          tmr_load_s, tmr_zero_s;
  logic [TW-1:0] tmr_val_s;

  assign beat_s       = mon_tvalid & mon_tready & mon_tlast;
  assign start_ok_s   = start & ~abort & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign abort_hit_s  = abort & (state_q != ST_IDLE) & (state_q != ST_ABORT);
  assign drain_exit_s = beat_s | (det_stopped & ~mon_tvalid);
  assign last_run_s   = ((run_count_q + 16'd1) >= runs_q);

  seq_timer #(.W(TW)) u_timer (
    .clk_i      (m00_axis_aclk),
    .rst_i      (m00_axis_areset),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .zero_o     (tmr_zero_s)
  );

  // State register.
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the timer zero flag means ARM/GAP/ABORT elapsed or watchdog expired.
  always_comb begin
    state_d = state_q;
    if (abort_hit_s) begin
      state_d = ST_ABORT;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = start_ok_s ? ST_ARM : ST_IDLE;
        ST_ARM:   state_d = tmr_zero_s ? ST_RUN : ST_ARM;
        ST_RUN: begin
          if (tmr_zero_s) begin
            state_d = ST_ABORT;
          end else if (det_stopped) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (tmr_zero_s) begin
            state_d = ST_ABORT;
          end else if (drain_exit_s) begin
            state_d = last_run_s ? ST_DONE : ST_GAP;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_GAP:   state_d = tmr_zero_s ? ST_ARM : ST_GAP;
        ST_DONE:  state_d = start_ok_s ? ST_ARM : ST_DONE;
        ST_ABORT: state_d = tmr_zero_s ? ST_IDLE : ST_ABORT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    en_d   = (state_d == ST_RUN) | (state_d == ST_DRAIN);
    trig_d = (state_d == ST_RUN);
    busy_d = (state_d != ST_IDLE) & (state_d != ST_DONE);
    done_d = (state_d == ST_DONE) & (state_q != ST_DONE);
  end

  // Timer reload on each phase entry; DRAIN keeps the watchdog running from RUN.
  always_comb begin
    tmr_load_s = (state_d != state_q) && (state_d != ST_DRAIN);
    case (state_d)
      ST_ARM, ST_ABORT: tmr_val_s = ARM_LOAD;
      ST_RUN:           tmr_val_s = WD_LOAD;
      ST_GAP:           tmr_val_s = (gap_q == 32'd0) ? '0 : TW'(gap_q) - TW'(1);
      default:          tmr_val_s = '0;
    endcase
  end

  // Configuration latch, run/packet counters and sticky error.
  always_comb begin
    runs_d      = runs_q;
    gap_d       = gap_q;
    time_d      = time_q;
    words_d     = words_q;
    run_count_d = run_count_q;
    pkt_d       = pkt_q;
    error_d     = error_q;
    if (start_ok_s) begin
      runs_d      = runs_eff(cfg_runs);
      gap_d       = cfg_gap_cycles;
      time_d      = cfg_measurement_time;
      words_d     = cfg_number_words;
      run_count_d = 16'd0;
      pkt_d       = 32'd0;
      error_d     = 1'b0;
    end else begin
      if ((state_q == ST_DRAIN) && ((state_d == ST_DONE) || (state_d == ST_GAP))) begin
        run_count_d = run_count_q + 16'd1;
      end else begin
        run_count_d = run_count_q;
      end
      if ((state_q != ST_IDLE) && beat_s) begin
        pkt_d = sat_inc(pkt_q);
      end else begin
        pkt_d = pkt_q;
      end
      if ((state_d == ST_ABORT) && (state_q != ST_ABORT)) begin
        error_d = 1'b1;
      end else begin
        error_d = error_q;
      end
    end
  end

  // Output and datapath registers.
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      en_q        <= 1'b0;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      runs_q      <= 16'd0;
      gap_q       <= 32'd0;
      time_q      <= 32'd0;
      words_q     <= 16'd0;
      run_count_q <= 16'd0;
      pkt_q       <= 32'd0;
    end else begin
      en_q        <= en_d;
      trig_q      <= trig_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      runs_q      <= runs_d;
      gap_q       <= gap_d;
      time_q      <= time_d;
      words_q     <= words_d;
      run_count_q <= run_count_d;
      pkt_q       <= pkt_d;
    end
  end

  assign det_enabled          = en_q;
  assign det_trigger          = trig_q;
  assign det_measurement_time = time_q;
  assign det_number_words     = words_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign error                = error_q;
  assign run_count            = run_count_q;
  assign packet_count         = pkt_q;

endmodule
